// File: rtl/fifo_rd_stream.sv
// Two-entry skid buffer that drains a show-ahead FIFO read port into a valid/ready stream.
// Define FIFO_RD_STREAM_CNT_EN to add the xfer_cnt transfer counter port.
module fifo_rd_stream #(
    parameter int DSIZE = 8,
    parameter int CNTW  = 16
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             rinc,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    output logic [CNTW-1:0]  xfer_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [DSIZE-1:0] skid;
    logic             pop;

    // Pop strobe depends only on registered occupancy, so m_ready never reaches rinc.
    assign rinc = !rempty && (state != FULL) && !rrst;
    assign pop  = m_valid && m_ready;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, as real flops do.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state   <= EMPTY;
            m_valid <= 1'b0;
            m_data  <= '0;
            skid    <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (rinc) begin
                        m_data  <= rdata;
                        m_valid <= 1'b1;
                        state   <= HALF;
                    end
                end
                HALF: begin
                    if (rinc && pop) begin
                        m_data <= rdata;
                    end else if (rinc) begin
                        skid  <= rdata;
                        state <= FULL;
                    end else if (pop) begin
                        m_valid <= 1'b0;
                        state   <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        m_data <= skid;
                        state  <= HALF;
                    end
                end
                default: begin
                    m_valid <= 1'b0;
                    state   <= EMPTY;
                end
            endcase
        end
    end

`ifdef FIFO_RD_STREAM_CNT_EN
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            xfer_cnt <= '0;
        end else if (pop) begin
            xfer_cnt <= xfer_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a queue-based FIFO source feeds the DUT and a
// monitor compares the stream against the words the DUT actually popped.
module tb_fifo_rd_stream;

    localparam int DSIZE = 8;
    localparam int CNTW  = 4;

    logic             rclk    = 1'b0;
    logic             rrst    = 1'b1;
    logic             rempty  = 1'b1;
    logic             m_ready = 1'b0;
    logic [DSIZE-1:0] rdata   = '0;
    logic             rinc;
    logic             m_valid;
    logic [DSIZE-1:0] m_data;
`ifdef FIFO_RD_STREAM_CNT_EN
    logic [CNTW-1:0]  xfer_cnt;
`endif

    fifo_rd_stream #(.DSIZE(DSIZE), .CNTW(CNTW)) dut (
        .rclk    (rclk),
        .rrst    (rrst),
        .rdata   (rdata),
        .rempty  (rempty),
        .rinc    (rinc),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready)
`ifdef FIFO_RD_STREAM_CNT_EN
        ,
        .xfer_cnt(xfer_cnt)
`endif
    );

    always #5 rclk = ~rclk;

    logic [DSIZE-1:0] src[$];    // words still inside the upstream FIFO
    logic [DSIZE-1:0] exp_q[$];  // words popped from the FIFO, not yet delivered
    int checks = 0, errors = 0;
    int rinc_cnt = 0, xfer_phase = 0, cur_run = 0, max_run = 0, xfers_model = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // One cycle of stimulus: drive on the falling edge, then account for the pop the DUT makes.
    task automatic step(input bit rst, input bit rdy, input bit gate_empty);
        @(negedge rclk);
        rrst    = rst;
        m_ready = rdy;
        if (rst) begin
            exp_q.delete();
            xfers_model = 0;
        end
        rempty = (src.size() == 0) || gate_empty;
        rdata  = (src.size() > 0) ? src[0] : DSIZE'($urandom);
        #2;
        if (rinc) rinc_cnt++;
        if (rinc && !rempty) exp_q.push_back(src.pop_front());
    endtask

    // Monitor: occupancy of the reference is the number of popped-but-undelivered words.
    initial begin
        int occ;
        forever begin
            @(negedge rclk);
            #1;
            occ = exp_q.size();
            check("m_valid", m_valid, occ > 0);
            check("rinc", rinc, !rrst && !rempty && occ < 2);
            if (rrst) check("m_data_rst", m_data, 0);
            else if (occ > 0) check("m_data", m_data, exp_q[0]);
`ifdef FIFO_RD_STREAM_CNT_EN
            check("xfer_cnt", xfer_cnt, xfers_model % (1 << CNTW));
`endif
            if (m_valid) cur_run++;
            else cur_run = 0;
            if (cur_run > max_run) max_run = cur_run;
            if (m_valid && m_ready && occ > 0) begin
                void'(exp_q.pop_front());
                xfers_model++;
                xfer_phase++;
            end
        end
    end

    initial begin
        // Reset with a word waiting: nothing popped until release, then A5 next cycle.
        src.push_back(8'hA5);
        repeat (3) step(1'b1, 1'b1, 1'b0);
        rinc_cnt = 0;
        repeat (4) step(1'b0, 1'b1, 1'b0);
        check("reset_release_rinc", rinc_cnt, 1);

        // Back-to-back stream of 16 words.
        for (int i = 1; i <= 16; i++) src.push_back(DSIZE'(i));
        rinc_cnt = 0;
        max_run  = 0;
        repeat (20) step(1'b0, 1'b1, 1'b0);
        check("stream_rinc", rinc_cnt, 16);
        check("stream_run", max_run, 16);
`ifdef FIFO_RD_STREAM_CNT_EN
        check("xfer_cnt_wrap", xfer_cnt, 1);
`endif

        // Stalled consumer: exactly two words taken, first word held.
        for (int i = 0; i < 5; i++) src.push_back(DSIZE'(8'h20 + i));
        rinc_cnt = 0;
        repeat (6) step(1'b0, 1'b0, 1'b0);
        check("stall_rinc", rinc_cnt, 2);
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, 8'h20);
        xfer_phase = 0;
        repeat (5) step(1'b0, 1'b1, 1'b0);
        check("stall_drain", xfer_phase, 5);

        // Reset while full: buffered words lost, FIFO resumes with its next word.
        for (int i = 0; i < 5; i++) src.push_back(DSIZE'(8'h30 + i));
        rinc_cnt = 0;
        repeat (4) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("full_reset_valid", m_valid, 0);
        repeat (8) step(1'b0, 1'b1, 1'b0);
        check("full_reset_rinc", rinc_cnt, 5);

        // Random backpressure, empty-flag gaps and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            while (src.size() < 3) src.push_back(DSIZE'($urandom));
            step($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2) == 0);
        end
        repeat (12) step(1'b0, 1'b1, 1'b0);
        check("drained", exp_q.size() + src.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter DSIZE, default 8, data width; it SHALL match the DSIZE of the FIFO it drains.
REQ-002 Parameter CNTW, default 16, transfer-counter width; it SHALL be used only when FIFO_RD_STREAM_CNT_EN is defined.
REQ-003 Port rclk, input, 1: read-domain clock; the block SHALL have a single clock, with all state updated on the rising edge of rclk.
REQ-004 Port rrst, input, 1: reset; it SHALL be asynchronous and active-high.
REQ-005 Port rdata, input, DSIZE: FIFO read data, valid combinationally whenever rempty=0 (show-ahead).
REQ-006 Port rempty, input, 1: FIFO empty flag, already synchronous to rclk.
REQ-007 Port rinc, output, 1: FIFO pop strobe; one pulse SHALL consume exactly one word.
REQ-008 Port m_data, output, DSIZE: stream data out.
REQ-009 Port m_valid, output, 1: m_data holds a word.
REQ-010 Port m_ready, input, 1: the downstream consumer accepts the word.
REQ-011 Port xfer_cnt, output, CNTW: count of completed stream transfers; this port SHALL exist only when FIFO_RD_STREAM_CNT_EN is defined.

Function
REQ-012 The block SHALL contain a two-entry buffer: a head register driving m_data and a skid register.
REQ-013 The state SHALL be one of EMPTY (occ=0), HALF (occ=1) or FULL (occ=2), held in a register; no other encodings are reachable.
REQ-014 rinc SHALL equal (!rempty && state!=FULL && !rrst), decoded from registered state only, with no combinational path from m_ready.
REQ-015 When rinc=1, rdata SHALL be captured on that same rclk edge: into the head if the head is empty after this cycle's pop, otherwise into the skid.
REQ-016 A pop SHALL occur when m_valid && m_ready; on a pop in FULL, the skid SHALL move to the head.
REQ-017 Transitions SHALL be: EMPTY: push->HALF; HALF: push only->FULL, pop only->EMPTY, push and pop->HALF; FULL: pop->HALF (push impossible); no event->hold.
REQ-018 m_valid SHALL be 1 exactly when state!=EMPTY, and it SHALL be registered.
REQ-019 Latency: a word with rempty=0 at edge N SHALL appear with m_valid=1 after edge N (first cycle after capture).
REQ-020 Throughput SHALL be 1 word/cycle sustained when rempty=0 and m_ready=1 continuously.
REQ-021 Ordering SHALL be strict FIFO: no word dropped, duplicated or reordered.
REQ-022 m_data and m_valid SHALL hold stable while m_valid=1 and m_ready=0.
REQ-023 With m_ready=0 and FIFO non-empty, exactly two words SHALL be popped, after which rinc=0 until a pop.
REQ-024 rempty rising in the same cycle as a pop SHALL produce no rinc, and the state SHALL decrement normally.
REQ-025 m_ready while m_valid=0 SHALL be ignored.

Reset
REQ-026 While rrst=1: state=EMPTY, m_valid=0, m_data=0, skid=0, rinc=0, and xfer_cnt=0 if present.
REQ-027 Reset asserted mid-operation SHALL discard buffered words without affecting FIFO contents or pointers.
REQ-028 On the first rclk edge after rrst deasserts, rinc SHALL be allowed if rempty=0.

Configuration
REQ-029 Macro FIFO_RD_STREAM_CNT_EN defined: xfer_cnt SHALL increment by 1 on each pop, wrapping from 2^CNTW-1 to 0.
REQ-030 Macro FIFO_RD_STREAM_CNT_EN undefined: the xfer_cnt port and counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Reset with rempty=0 and rdata=8'hA5 -> rinc=0, m_valid=0, m_data=0 while rrst=1; after release, rinc=1 at the first edge and m_valid=1 with m_data=8'hA5 next cycle.
REQ-032 Streaming 8'h01..8'h10, m_ready=1 -> 16 consecutive m_valid cycles, data 01..10 in order, 16 rinc pulses total.
REQ-033 m_ready=0, FIFO holding 5 words -> exactly 2 rinc pulses, state FULL, m_data=first word held; then m_ready=1 -> remaining 5 words in order, no gaps.
REQ-034 Alternating m_ready 1/0 with rempty toggling -> output sequence equals input sequence, and rinc is never asserted while rempty=1 or state=FULL.
REQ-035 rrst pulsed while FULL -> m_valid=0 immediately (asynchronous), 2 buffered words lost, next word from FIFO delivered first.
REQ-036 With FIFO_RD_STREAM_CNT_EN and CNTW=4: 17 transfers -> xfer_cnt = 1 (wrap); without the macro, the build has no xfer_cnt port.
